axi_fft_master: RTL and testbench

AXI_FFT_MASTER -- requirements
Module: axi_fft_master

---
 rtl/axi_fft_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_axi_fft_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fft_master.sv
// axi_fft_master
// Sequences one FFT job over a simple AXI-style master port:
//   1. write a burst of len+1 16-bit samples (AW, W, B)
//   2. wait for the FFT engine to signal completion (i_CALC_END)
//   3. read back len+1 results (AR, R) into a one-entry output register
//   4. pulse o_DONE once the output register has drained
//
// Ports
//   i_clk, i_rstn                       clock, async active-low reset
//   i_START/i_BASE/i_LEN/i_WID/i_RID_SEL job command (latched in IDLE)
//   i_S_* / o_S_READY                   sample source handshake
//   o_Q_* / i_Q_READY                   result sink handshake
//   i_CALC_END, o_BUSY, o_DONE, o_ERR   job status
//   o_AW*, o_W*, o_BREADY, o_AR*, o_RREADY and matching inputs: AXI channels
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for i_START
// AW      | write address valid, waiting for i_AWREADY
// W       | streaming samples through the holding register
// B       | waiting for write response
// WAIT    | waiting for i_CALC_END
// AR      | read address valid, waiting for i_ARREADY
// R       | receiving result beats into the output register
// DONE    | draining output register, then o_DONE pulse

module axi_fft_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_W_WIDTH = 2,
  parameter int ID_R_WIDTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_START,
  input  logic [11:0]           i_BASE,
  input  logic [7:0]            i_LEN,
  input  logic [ID_W_WIDTH-1:0] i_WID,
  input  logic [ID_R_WIDTH-1:0] i_RID_SEL,
  input  logic [15:0]           i_S_DATA,
  input  logic                  i_S_VALID,
  output logic                  o_S_READY,
  output logic [DATA_WIDTH-1:0] o_Q_DATA,
  output logic                  o_Q_VALID,
  input  logic                  i_Q_READY,
  input  logic                  i_CALC_END,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ERR,
  output logic [11:0]           o_AWADDR,
  output logic [7:0]            o_AWLEN,
  output logic [2:0]            o_AWSIZE,
  output logic [1:0]            o_AWBURST,
  output logic [ID_W_WIDTH-1:0] o_AWID,
  output logic                  o_AWVALID,
  input  logic                  i_AWREADY,
  output logic [15:0]           o_WDATA,
  output logic [1:0]            o_WSTRB,
  output logic                  o_WVALID,
  output logic                  o_WLAST,
  input  logic                  i_WREADY,
  input  logic                  i_BVALID,
  input  logic [ID_W_WIDTH-1:0] i_BID,
  output logic                  o_BREADY,
  output logic [11:0]           o_ARADDR,
  output logic [7:0]            o_ARLEN,
  output logic [2:0]            o_ARSIZE,
  output logic [1:0]            o_ARBURST,
  output logic [ID_R_WIDTH-1:0] o_ARID,
  output logic                  o_ARVALID,
  input  logic                  i_ARREADY,
  input  logic [DATA_WIDTH-1:0] i_RDATA,
  input  logic [ID_R_WIDTH-1:0] i_RID,
  input  logic                  i_RVALID,
  input  logic                  i_RLAST,
  output logic                  o_RREADY
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_AW, ST_W, ST_B, ST_WAIT, ST_AR, ST_R, ST_DONE
  } state_t;

  state_t                  state;
  logic [11:0]             base;
  logic [7:0]              len;
  logic [ID_W_WIDTH-1:0]   wid;
  logic [ID_R_WIDTH-1:0]   rid;
  logic [7:0]              wcnt;
  logic [7:0]              lcnt;
  logic [7:0]              rcnt;
  logic                    load_done;
  logic                    w_full;
  logic [15:0]             w_data;
  logic                    q_full;
  logic [DATA_WIDTH-1:0]   q_data;
  logic                    awvalid;
  logic                    bready;
  logic                    arvalid;
  logic                    busy;
  logic                    done;
  logic                    err;

  logic w_hs;
  logic s_acc;
  logic q_free;
  logic r_hs;
  logic r_end;

  assign w_hs   = (state == ST_W) && w_full && i_WREADY;
  // The holding register can refill in the same cycle it is emptied,
  // which keeps the write stream at one beat per cycle.
  assign o_S_READY = (state == ST_W) && !load_done && (!w_full || i_WREADY);
  assign s_acc  = i_S_VALID && o_S_READY;
  assign q_free = !q_full || i_Q_READY;
  assign o_RREADY = (state == ST_R) && q_free;
  assign r_hs   = i_RVALID && o_RREADY;
  assign r_end  = i_RLAST || (rcnt == len);

  assign o_AWADDR  = base;
  assign o_AWLEN   = len;
  assign o_AWSIZE  = 3'b001;
  assign o_AWBURST = 2'b01;
  assign o_AWID    = wid;
  assign o_AWVALID = awvalid;

  assign o_WDATA   = w_data;
  assign o_WSTRB   = 2'b11;
  assign o_WVALID  = w_full;
  assign o_WLAST   = w_full && (wcnt == len);

  assign o_BREADY  = bready;

  assign o_ARADDR  = base;
  assign o_ARLEN   = len;
  assign o_ARSIZE  = 3'b010;
  assign o_ARBURST = 2'b01;
  assign o_ARID    = rid;
  assign o_ARVALID = arvalid;

  assign o_Q_DATA  = q_data;
  assign o_Q_VALID = q_full;
  assign o_BUSY    = busy;
  assign o_DONE    = done;
  assign o_ERR     = err;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= ST_IDLE;
      base      <= '0;
      len       <= '0;
      wid       <= '0;
      rid       <= '0;
      wcnt      <= '0;
      lcnt      <= '0;
      rcnt      <= '0;
      load_done <= 1'b0;
      w_full    <= 1'b0;
      w_data    <= '0;
      q_full    <= 1'b0;
      q_data    <= '0;
      awvalid   <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (s_acc) begin
        w_data <= i_S_DATA;
        lcnt   <= lcnt + 8'd1;
        if (lcnt == len) load_done <= 1'b1;
      end
      if (s_acc)     w_full <= 1'b1;
      else if (w_hs) w_full <= 1'b0;
      if (w_hs) wcnt <= wcnt + 8'd1;

      // A new beat overwrites a word being drained in the same cycle.
      if (r_hs) begin
        q_data <= i_RDATA;
        q_full <= 1'b1;
        rcnt   <= rcnt + 8'd1;
      end else if (i_Q_READY) begin
        q_full <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (i_START) begin
            base      <= i_BASE;
            len       <= i_LEN;
            wid       <= i_WID;
            rid       <= i_RID_SEL;
            err       <= 1'b0;
            wcnt      <= '0;
            lcnt      <= '0;
            rcnt      <= '0;
            load_done <= 1'b0;
            awvalid   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_AW;
          end
        end
        ST_AW: begin
          if (i_AWREADY) begin
            awvalid <= 1'b0;
            state   <= ST_W;
          end
        end
        ST_W: begin
          if (w_hs && o_WLAST) begin
            bready <= 1'b1;
            state  <= ST_B;
          end
        end
        ST_B: begin
          if (i_BVALID) begin
            bready <= 1'b0;
            if (i_BID != wid) err <= 1'b1;
            state  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_CALC_END) begin
            arvalid <= 1'b1;
            state   <= ST_AR;
          end
        end
        ST_AR: begin
          if (i_ARREADY) begin
            arvalid <= 1'b0;
            state   <= ST_R;
          end
        end
        ST_R: begin
          if (r_hs) begin
            // Early or missing RLAST and wrong IDs only flag; the job runs on.
            if (i_RLAST != (rcnt == len)) err <= 1'b1;
            if (i_RID != rid)             err <= 1'b1;
            if (r_end)                    state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (q_free) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_fft_master.sv
// tb_axi_fft_master
// Directed bench for axi_fft_master. The task run_job plays the AXI slave,
// sample source and result sink for one job; expected values come from the
// job parameters (sample base, 0xA0.. read data, RLAST position, IDs).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.

module tb_axi_fft_master;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        START;
  logic [11:0] BASE;
  logic [7:0]  LEN;
  logic [1:0]  WID, RID_SEL;
  logic [15:0] S_DATA;
  logic        S_VALID, S_READY;
  logic [31:0] Q_DATA;
  logic        Q_VALID, Q_READY;
  logic        CALC_END, BUSY, DONE, ERR;
  logic [11:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST, AWID;
  logic        AWVALID, AWREADY;
  logic [15:0] WDATA;
  logic [1:0]  WSTRB;
  logic        WVALID, WLAST, WREADY;
  logic        BVALID, BREADY;
  logic [1:0]  BID;
  logic [11:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST, ARID;
  logic        ARVALID, ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RID;
  logic        RVALID, RLAST, RREADY;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axi_fft_master #(.DATA_WIDTH(32), .ID_W_WIDTH(2), .ID_R_WIDTH(2)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_START(START), .i_BASE(BASE), .i_LEN(LEN), .i_WID(WID), .i_RID_SEL(RID_SEL),
    .i_S_DATA(S_DATA), .i_S_VALID(S_VALID), .o_S_READY(S_READY),
    .o_Q_DATA(Q_DATA), .o_Q_VALID(Q_VALID), .i_Q_READY(Q_READY),
    .i_CALC_END(CALC_END), .o_BUSY(BUSY), .o_DONE(DONE), .o_ERR(ERR),
    .o_AWADDR(AWADDR), .o_AWLEN(AWLEN), .o_AWSIZE(AWSIZE), .o_AWBURST(AWBURST),
    .o_AWID(AWID), .o_AWVALID(AWVALID), .i_AWREADY(AWREADY),
    .o_WDATA(WDATA), .o_WSTRB(WSTRB), .o_WVALID(WVALID), .o_WLAST(WLAST),
    .i_WREADY(WREADY),
    .i_BVALID(BVALID), .i_BID(BID), .o_BREADY(BREADY),
    .o_ARADDR(ARADDR), .o_ARLEN(ARLEN), .o_ARSIZE(ARSIZE), .o_ARBURST(ARBURST),
    .o_ARID(ARID), .o_ARVALID(ARVALID), .i_ARREADY(ARREADY),
    .i_RDATA(RDATA), .i_RID(RID), .i_RVALID(RVALID), .i_RLAST(RLAST),
    .o_RREADY(RREADY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    START = 0; BASE = '0; LEN = '0; WID = '0; RID_SEL = '0;
    S_DATA = '0; S_VALID = 0; Q_READY = 1; CALC_END = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BID = '0; ARREADY = 0;
    RDATA = '0; RID = '0; RVALID = 0; RLAST = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {21'd0, AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY,
                           S_READY, Q_VALID, DONE, ERR, BUSY}, 32'd0);
    check({tag, "_wdata"}, {16'd0, WDATA}, 32'd0);
    check({tag, "_qdata"}, Q_DATA, 32'd0);
    check({tag, "_awaddr"}, {20'd0, AWADDR}, 32'd0);
  endtask

  // One complete job. rlast_idx: beat index carrying RLAST (== len for a clean
  // burst). qstall_at: hold Q_READY low 2 cycles once that many results have
  // drained (-1 = never). rst_at_w: assert reset once that many W beats
  // have completed (0 = never).
  task automatic run_job(input logic [11:0] base, input logic [7:0] len,
                         input logic [1:0] wid, input logic [1:0] rid,
                         input logic [1:0] bid_ret, input int rlast_idx,
                         input bit wtoggle, input int aw_delay, input int calc_delay,
                         input int qstall_at, input int rst_at_w,
                         input logic [15:0] sbase);
    int cyc = 0, sidx = 0, wbeats = 0, aw_cycles = 0, aw_seen = 0, ar_seen = 0;
    int ridx = 0, qbeats = 0, dones = 0, wait_cnt = 0, calc_cyc = -1;
    int ar_early = 0, rready_low = 0, last_wcyc = -1, busy_bad = 0, stall_left = 2;
    int nbeats_exp;
    bit w_last_seen = 0, b_seen = 0, b_chk = 0, r_active = 0, r_done = 0;
    bit prev_stall = 0, done_seen = 0, rst_hit = 0, err_exp;
    logic [15:0] prev_wdata = '0;

    nbeats_exp = (rlast_idx < int'(len)) ? rlast_idx + 1 : int'(len) + 1;
    err_exp    = (bid_ret != wid) || (rlast_idx != int'(len));

    @(posedge clk); #1;
    START = 1; BASE = base; LEN = len; WID = wid; RID_SEL = rid;

    while (!done_seen && !rst_hit && cyc < 400) begin
      @(posedge clk); #1;
      // START with a different base while busy must be ignored
      START    = (cyc >= 3 && cyc < 6);
      BASE     = base ^ 12'hFFF;
      AWREADY  = (cyc >= aw_delay);
      WREADY   = wtoggle ? (cyc % 2 == 0) : 1'b1;
      S_VALID  = 1;
      S_DATA   = sbase + 16'(sidx);
      BVALID   = w_last_seen && !b_seen;
      BID      = bid_ret;
      CALC_END = b_seen && (wait_cnt >= calc_delay);
      if (CALC_END && calc_cyc < 0) calc_cyc = cyc;
      ARREADY  = 1;
      RVALID   = r_active && !r_done;
      RDATA    = 32'hA0 + 32'(ridx);
      RID      = rid;
      RLAST    = (ridx == rlast_idx);
      if (qstall_at >= 0 && qbeats == qstall_at && stall_left > 0) begin
        Q_READY = 0;
        stall_left--;
      end else begin
        Q_READY = 1;
      end

      if (rst_at_w > 0 && wbeats == rst_at_w) begin
        check("rst_w_beat_pending", {31'd0, WVALID}, 32'd1);
        rstn = 0;
        #1;
        check_all_zero("rst_mid");
        rst_hit = 1;
      end else begin
        @(negedge clk);
        if (cyc == 0) check("err_cleared_on_start", {31'd0, ERR}, 32'd0);
        if (!DONE && !BUSY) busy_bad++;

        if (AWVALID) begin
          aw_cycles++;
          check("awaddr", {20'd0, AWADDR}, {20'd0, base});
          check("awlen", {24'd0, AWLEN}, {24'd0, len});
          check("awsize", {29'd0, AWSIZE}, 32'd1);
          check("awburst", {30'd0, AWBURST}, 32'd1);
          check("awid", {30'd0, AWID}, {30'd0, wid});
          if (AWREADY) aw_seen++;
        end

        if (prev_stall) begin
          check("w_stall_valid", {31'd0, WVALID}, 32'd1);
          check("w_stall_data", {16'd0, WDATA}, {16'd0, prev_wdata});
        end
        prev_stall = WVALID && !WREADY;
        prev_wdata = WDATA;
        if (WVALID && WREADY) begin
          check("wdata_order", {16'd0, WDATA}, {16'd0, sbase + 16'(wbeats)});
          check("wlast", {31'd0, WLAST}, {31'd0, (wbeats == int'(len))});
          check("wstrb", {30'd0, WSTRB}, 32'd3);
          if (!wtoggle && wbeats > 0) check("w_back_to_back", cyc, last_wcyc + 1);
          last_wcyc = cyc;
          wbeats++;
          if (WLAST) w_last_seen = 1;
        end
        if (S_VALID && S_READY) sidx++;

        if (b_chk) begin
          check("err_after_b", {31'd0, ERR}, {31'd0, (bid_ret != wid)});
          b_chk = 0;
        end
        if (b_seen) wait_cnt++;
        if (BVALID && BREADY) begin
          b_seen = 1;
          b_chk  = 1;
        end

        if (ARVALID && (calc_cyc < 0 || cyc == calc_cyc)) ar_early++;
        if (calc_cyc >= 0 && cyc == calc_cyc + 1)
          check("ar_after_calc", {31'd0, ARVALID}, 32'd1);
        if (ARVALID) begin
          check("araddr", {20'd0, ARADDR}, {20'd0, base});
          check("arlen", {24'd0, ARLEN}, {24'd0, len});
          check("arsize", {29'd0, ARSIZE}, 32'd2);
          check("arburst", {30'd0, ARBURST}, 32'd1);
          check("arid", {30'd0, ARID}, {30'd0, rid});
          ar_seen++;
          r_active = 1;
        end

        if (RVALID && !RREADY) rready_low++;
        if (RVALID && RREADY) begin
          if (RLAST || ridx == int'(len)) r_done = 1;
          ridx++;
        end
        if (Q_VALID && Q_READY) begin
          check("q_data", Q_DATA, 32'hA0 + 32'(qbeats));
          qbeats++;
        end
        if (DONE) begin
          dones++;
          check("done_after_drain", qbeats, nbeats_exp);
          check("busy_with_done", {31'd0, BUSY}, 32'd0);
          done_seen = 1;
        end
      end
      cyc++;
    end

    if (!rst_hit) begin
      START = 0;
      check("job_completed", {31'd0, done_seen}, 32'd1);
      check("aw_handshakes", aw_seen, 1);
      check("aw_valid_cycles", aw_cycles, aw_delay + 1);
      check("w_beats", wbeats, int'(len) + 1);
      check("ar_before_calc_end", ar_early, 0);
      check("ar_handshakes", ar_seen, 1);
      check("q_beats", qbeats, nbeats_exp);
      check("err_final", {31'd0, ERR}, {31'd0, err_exp});
      check("busy_during_job", busy_bad, 0);
      if (qstall_at >= 0) check("rready_dropped", {31'd0, (rready_low > 0)}, 32'd1);
      repeat (3) begin
        @(negedge clk);
        if (DONE) dones++;
        check("idle_after_done", {31'd0, BUSY}, 32'd0);
      end
      check("done_single_pulse", dones, 1);
    end
  endtask

  initial begin
    idle_inputs();
    rstn = 0;
    #12;
    check_all_zero("rst_init");
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    check_all_zero("after_release");

    // clean job, 20-cycle compute wait, sink stall after the first result
    run_job(12'h010, 8'd3, 2'd1, 2'd2, 2'd1, 3, 1'b0, 0, 20, 1, 0, 16'h1000);
    // WREADY toggling, AW held off two cycles
    run_job(12'h020, 8'd3, 2'd2, 2'd1, 2'd2, 3, 1'b1, 2, 0, -1, 0, 16'h2000);
    // BID mismatch and early RLAST on beat 2 of 4
    run_job(12'h030, 8'd3, 2'd2, 2'd3, 2'd1, 1, 1'b0, 0, 0, -1, 0, 16'h3000);
    // following start clears the sticky error
    run_job(12'h040, 8'd3, 2'd1, 2'd1, 2'd1, 3, 1'b0, 0, 0, -1, 0, 16'h4000);
    // reset during W beat 2
    run_job(12'h050, 8'd3, 2'd1, 2'd1, 2'd1, 3, 1'b0, 0, 0, -1, 1, 16'h5000);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rstn = 1;
    @(negedge clk);
    check_all_zero("rst_release");
    // fresh job after the abort
    run_job(12'h060, 8'd3, 2'd0, 2'd0, 2'd0, 3, 1'b1, 1, 2, 2, 0, 16'h6000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
